// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the pmem model: one op in flight, lane-aligned stores, extended loads.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned ops complete with out_err and issue no memory request.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_wen_q, mem_wen_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_rdata_q, out_rdata_d;
    logic              out_err_q, out_err_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        req_mask_c;
    logic [31:0]       req_wdata_c;
    logic [31:0]       rd_shift_c;
    logic [31:0]       load_data_c;
    logic              misalign_trap_c;

    // Store lane placement; masks past lane 3 are truncated.
    always_comb begin
        req_mask_c  = 4'b1111;
        req_wdata_c = in_wdata;
        case (in_funct3[1:0])
            2'b00: begin
                req_mask_c  = 4'b0001 << in_addr[1:0];
                req_wdata_c = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                req_mask_c  = 4'b0011 << in_addr[1:0];
                req_wdata_c = {2{in_wdata[15:0]}};
            end
            default: begin
                req_mask_c  = 4'b1111;
                req_wdata_c = in_wdata;
            end
        endcase
        if (!in_wen) begin
            req_mask_c = 4'b0000;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_c;
    always_comb begin
        case (in_funct3[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = in_addr[0];
            default: misalign_c = |in_addr[1:0];
        endcase
    end
    assign misalign_trap_c = misalign_c;
`else
    assign misalign_trap_c = 1'b0;
`endif

    // Load extraction; zeros shifted in above byte 3 keep a half at offset 3 unsigned.
    always_comb begin
        rd_shift_c = mem_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_data_c = {{24{~funct3_q[2] & rd_shift_c[7]}}, rd_shift_c[7:0]};
            2'b01:   load_data_c = {{16{~funct3_q[2] & rd_shift_c[15]}}, rd_shift_c[15:0]};
            default: load_data_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wdata_q     <= 32'h0;
            mem_wmask_q     <= 4'h0;
            out_valid_q     <= 1'b0;
            out_rdata_q     <= 32'h0;
            out_err_q       <= 1'b0;
            funct3_q        <= 3'h0;
            off_q           <= 2'h0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            out_valid_q     <= out_valid_d;
            out_rdata_q     <= out_rdata_d;
            out_err_q       <= out_err_d;
            funct3_q        <= funct3_d;
            off_q           <= off_d;
            cnt_q           <= cnt_d;
        end
    end

    // Next state; handshake outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_wen_d       = mem_wen_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        out_rdata_d     = out_rdata_q;
        out_err_d       = out_err_q;
        funct3_d        = funct3_q;
        off_d           = off_q;
        cnt_d           = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    funct3_d    = in_funct3;
                    off_d       = in_addr[1:0];
                    out_rdata_d = 32'h0;
                    out_err_d   = 1'b0;
                    if (misalign_trap_c) begin
                        state_d   = S_DONE;
                        out_err_d = 1'b1;
                    end else begin
                        state_d         = S_ISSUE;
                        mem_req_valid_d = 1'b1;
                        mem_wen_d       = in_wen;
                        mem_addr_d      = {in_addr[31:2], 2'b00};
                        mem_wdata_d     = req_wdata_c;
                        mem_wmask_d     = req_mask_c;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d         = S_WAIT;
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d     = S_DONE;
                    out_rdata_d = mem_wen_q ? 32'h0 : load_data_c;
                    out_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    out_rdata_d = 32'h0;
                    out_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_wen       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-level reference model of memory and lane rules.
module tb_lsu_mem_ctrl;

    localparam int unsigned TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wen = 1'b0;
    logic [2:0]  in_funct3 = 3'b0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] mem [16];
    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_mask;
    logic        last_err;

    lsu_mem_ctrl #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(11)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask(input logic wen, input logic [2:0] f3, input logic [1:0] o);
        int nb;
        logic [3:0] m;
        nb = nbytes(f3);
        m = 4'h0;
        if (!wen) return 4'h0;
        if (nb == 4) return 4'hF;
        for (int i = 0; i < 4; i++)
            if (i >= int'(o) && i < int'(o) + nb) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int nb;
        logic [31:0] w;
        nb = nbytes(f3);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] word);
        int nb;
        logic [31:0] v;
        nb = nbytes(f3);
        if (nb == 4) return word;
        v = 32'h0;
        for (int i = 0; i < nb; i++)
            if (int'(o) + i < 4) v[8*i +: 8] = word[8*(int'(o) + i) +: 8];
        if (!f3[2] && v[8*nb - 1])
            for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
        int nb;
        nb = nbytes(f3);
        return (nb == 2 && o[0]) || (nb == 4 && o != 2'b00);
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({pfx, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        check_eq({pfx, "_mem_wen"}, 32'(mem_wen), 32'd0);
        check_eq({pfx, "_mem_addr"}, mem_addr, 32'h0);
        check_eq({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        check_eq({pfx, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
        check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({pfx, "_out_rdata"}, out_rdata, 32'h0);
        check_eq({pfx, "_out_err"}, 32'(out_err), 32'd0);
    endtask

    // One op end to end; resp_dly < 0 means memory never answers.
    task automatic do_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int req_dly, input int resp_dly, input int out_dly);
        logic [1:0]  o;
        logic [3:0]  emask;
        logic [31:0] ewdata, eaddr, erdata;
        logic        eerr, skip_mem;
        int          n, acc_cyc, idx;
        o = addr[1:0];
        idx = int'(addr[5:2]);
        eaddr = {addr[31:2], 2'b00};
        emask = exp_mask(wen, f3, o);
        ewdata = exp_wdata(f3, wdata);
        erdata = 32'h0;
        eerr = 1'b0;
        skip_mem = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        skip_mem = misaligned(f3, o);
`endif
        n = 0;
        while (!in_ready && n < 64) begin @(negedge clk); n++; end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0; in_wen = 1'($urandom); in_funct3 = 3'($urandom);
        in_addr = $urandom; in_wdata = $urandom;
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);
        if (skip_mem) begin
            check_eq("misal_no_req", 32'(mem_req_valid), 32'd0);
            check_eq("misal_valid_n1", 32'(out_valid), 32'd1);
            eerr = 1'b1;
        end else begin
            for (int i = 0; i <= req_dly; i++) begin
                check_eq("req_valid", 32'(mem_req_valid), 32'd1);
                check_eq("req_wen", 32'(mem_wen), 32'(wen));
                check_eq("req_addr", mem_addr, eaddr);
                check_eq("req_wmask", 32'(mem_wmask), 32'(emask));
                if (wen) check_eq("req_wdata", mem_wdata, ewdata);
                check_eq("issue_out_valid", 32'(out_valid), 32'd0);
                check_eq("issue_in_ready", 32'(in_ready), 32'd0);
                last_addr = mem_addr; last_mask = mem_wmask; last_wdata = mem_wdata;
                mem_resp_valid = 1'($urandom);
                if (i == req_dly) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_dly < 0) begin
                n = 0;
                while (!out_valid && n < int'(TIMEOUT) + 16) begin @(negedge clk); n++; end
                check_eq("timeout_cycles", 32'(n), 32'(TIMEOUT));
                eerr = 1'b1;
            end else begin
                for (int i = 0; i < resp_dly; i++) begin
                    check_eq("wait_out_valid", 32'(out_valid), 32'd0);
                    @(negedge clk);
                end
                mem_resp_valid = 1'b1;
                mem_rdata = wen ? $urandom : mem[idx];
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_rdata = $urandom;
                if (wen) begin
                    for (int b = 0; b < 4; b++)
                        if (emask[b]) mem[idx][8*b +: 8] = ewdata[8*b +: 8];
                end else begin
                    erdata = exp_load(f3, o, mem[idx]);
                end
                if (req_dly == 0 && resp_dly == 0)
                    check_eq("min_latency", 32'(cyc - acc_cyc), 32'd2);
            end
        end
        for (int i = 0; i <= out_dly; i++) begin
            check_eq("out_valid", 32'(out_valid), 32'd1);
            check_eq("out_rdata", out_rdata, erdata);
            check_eq("out_err", 32'(out_err), 32'(eerr));
            check_eq("done_in_ready", 32'(in_ready), 32'd0);
            check_eq("done_req_valid", 32'(mem_req_valid), 32'd0);
            last_rdata = out_rdata; last_err = out_err;
            mem_resp_valid = 1'($urandom);
            if (i == out_dly) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        mem_resp_valid = 1'b0;
        check_eq("in_ready_after", 32'(in_ready), 32'd1);
        check_eq("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] st_f3 [6];
        logic       w;
        logic [2:0] f;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Load extension from a known word.
        mem[4] = 32'h8899AABB;
        do_op(1'b0, 3'b000, 32'h80000013, 32'h0, 0, 0, 0);
        check_eq("lb_val", last_rdata, 32'hFFFFFF88);
        check_eq("lb_addr", last_addr, 32'h80000010);
        check_eq("lb_mask", 32'(last_mask), 32'h0);
        do_op(1'b0, 3'b100, 32'h80000013, 32'h0, 0, 0, 0);
        check_eq("lbu_val", last_rdata, 32'h00000088);
        do_op(1'b0, 3'b001, 32'h80000012, 32'h0, 0, 0, 0);
        check_eq("lh_val", last_rdata, 32'hFFFF8899);
        do_op(1'b0, 3'b010, 32'h80000010, 32'h0, 0, 0, 0);
        check_eq("lw_val", last_rdata, 32'h8899AABB);

        // Stores.
        do_op(1'b1, 3'b000, 32'h80000021, 32'h000000CD, 0, 0, 0);
        check_eq("sb_mask", 32'(last_mask), 32'h2);
        check_eq("sb_wdata", last_wdata, 32'hCDCDCDCD);
        check_eq("sb_addr", last_addr, 32'h80000020);
        check_eq("sb_rdata", last_rdata, 32'h0);
        do_op(1'b1, 3'b001, 32'h80000022, 32'h00001234, 0, 0, 0);
        check_eq("sh_mask", 32'(last_mask), 32'hC);
        check_eq("sh_wdata", last_wdata, 32'h12341234);

        // Handshake stalls on both sides.
        do_op(1'b0, 3'b010, 32'h80000010, 32'h0, 5, 2, 3);

        // Timeout, then a normal op.
        do_op(1'b0, 3'b010, 32'h80000004, 32'h0, 0, -1, 1);
        check_eq("timeout_err", 32'(last_err), 32'd1);
        do_op(1'b0, 3'b101, 32'h80000016, 32'h0, 0, 0, 0);

        // Reset while waiting for a response.
        in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h80000030;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
            check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
            check_eq("midrst_no_req", 32'(mem_req_valid), 32'd0);
            @(negedge clk);
        end

        // Misaligned word load.
        do_op(1'b0, 3'b010, 32'h80000002, 32'h0, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        check_eq("misal_err", 32'(last_err), 32'd1);
        check_eq("misal_rdata", last_rdata, 32'h0);
`else
        check_eq("misal_addr", last_addr, 32'h80000000);
        check_eq("misal_err", 32'(last_err), 32'd0);
`endif

        // Random ops against the model.
        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom);
            f = w ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
            do_op(w, f, 32'h80000000 + 32'($urandom_range(0, 63)), $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly upstream of the pmem DPI memory model in the NPC core.
- Takes one load/store op from EXU via valid/ready and issues one word-aligned request to memory.
- Stores: converts RV32 byte/half/word stores into word address, lane-shifted data and a 4-bit byte mask.
- Loads: extracts and sign/zero-extends the returned word, then hands the result to WBU via valid/ready.
- Strictly one transaction outstanding.

Parameters:
- TIMEOUT_CYC, 1024: max cycles in WAIT before the op completes with err=1.
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU presents an op
- in_ready  out  1  LSU can accept an op
- in_wen  in  1  1=store, 0=load
- in_funct3  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- in_addr  in  32  effective byte address
- in_wdata  in  32  store data (rs2)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  write request
- mem_addr  out  32  in_addr with bits [1:0] cleared
- mem_wdata  out  32  store data shifted to byte lane
- mem_wmask  out  4  byte-lane enables, zero for loads
- mem_resp_valid  in  1  memory completed (read data valid / write done)
- mem_rdata  in  32  read word
- out_valid  out  1  result ready for WBU
- out_ready  in  1  WBU accepts result
- out_rdata  out  32  extended load data, 0 for stores
- out_err  out  1  timeout or misaligned (see optional feature)

Behaviour:
- Reset: state=IDLE; in_ready=1; mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0; out_valid=0, out_rdata=0, out_err=0; timeout counter=0.
- rst mid-transaction: abandon immediately; any later mem_resp_valid from the abandoned request is ignored while in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid & in_ready: latch op; all mem_* outputs registered; go to ISSUE.
- ISSUE:
  - mem_req_valid=1; mem_* outputs held stable until mem_req_ready.
  - mem_req_ready=1: go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid=1: latch result, go to DONE.
  - Counter reaches TIMEOUT_CYC-1 without a response: out_err=1, out_rdata=0, go to DONE.
  - Response and timeout in the same cycle: the response wins.
- DONE:
  - out_valid=1, outputs held until out_ready; then go to IDLE.
  - in_ready=0 in every state except IDLE.
- mem_resp_valid outside WAIT is ignored.
- Minimum latency with memory ready/responding immediately: accept at cycle N, request at N+1, response sampled at N+2, out_valid at N+3. Back-to-back ops: next accept earliest at N+4.
- Lane offset o = addr[1:0].
  - SB: wmask = 0001 << o; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 0011 << o; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 1111; wdata unchanged.
- Loads:
  - byte = rdata >> (8*o).
  - LB / LH: sign-extend [7:0] / [15:0].
  - LBU / LHU: zero-extend.
  - LW: rdata unchanged.
- Undefined funct3 (011, 110, 111): treated as W.
- Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) without the optional feature:
  - Lanes computed as above, truncated to 4 bits.
  - Half at o=3 writes lane 3 only and reads byte 3 with zero upper byte.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned op goes IDLE -> DONE directly with no memory request.
  - Result: out_err=1, out_rdata=0.
- Undefined:
  - No check; behaviour as described in Behaviour.
  - out_err is set by timeout only.

Test Plan:
- Load extension:
  - Setup: memory word at 0x80000010 = 0x8899AABB.
  - LB addr 0x80000013 -> out_rdata 0xFFFFFF88.
  - LBU -> 0x00000088.
  - LH addr 0x80000012 -> 0xFFFF8899.
  - LW addr 0x80000010 -> 0x8899AABB.
  - All loads: mem_addr 0x80000010, mem_wmask 0000.
- Stores:
  - SB 0x80000021 with wdata 0x000000CD -> mem_wmask 0010, mem_wdata 0xCDCDCDCD, mem_addr 0x80000020.
  - SH 0x80000022 with wdata 0x00001234 -> mask 1100, wdata 0x12341234.
  - Both: out_rdata 0.
- Handshake stalls:
  - Hold mem_req_ready=0 for 5 cycles, then out_ready=0 for 3 cycles.
  - Required: mem_* and out_* stable throughout; in_ready=0 until the cycle after out_valid&out_ready.
- Timeout: never assert mem_resp_valid -> out_valid with out_err=1 exactly TIMEOUT_CYC cycles after the mem_req handshake; next op accepted normally.
- Reset mid-op:
  - Assert rst in WAIT, then pulse mem_resp_valid after reset.
  - Required: all outputs at reset values, in_ready=1, no out_valid produced.
- Misalignment: LW at 0x80000002.
  - With LSU_MISALIGN_CHECK_EN: no mem_req_valid; out_err=1 at N+1.
  - Without: mem_addr 0x80000000, out_err=0.
